// File: rtl/imm_gen_pipe.sv
// Registered RISC-V immediate generator with ready/valid handshake and a main + skid buffer.
// Optional macro IMMGEN_ZICSR_EN enables the Z (CSR uimm) format; without it Z is illegal.
module imm_gen_pipe #(
  parameter int XLEN        = 32,
  parameter int AUTO_DECODE = 1,
  parameter int TAG_W       = 4,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [2:0]       fmt_sel,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam logic [2:0] FMT_I = 3'b000;
  localparam logic [2:0] FMT_S = 3'b001;
  localparam logic [2:0] FMT_B = 3'b010;
  localparam logic [2:0] FMT_U = 3'b011;
  localparam logic [2:0] FMT_J = 3'b100;
  localparam logic [2:0] FMT_Z = 3'b101;
  localparam logic [2:0] FMT_BAD = 3'b111;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [2:0]       fmt_s;
  logic             ill_s;
  logic [31:0]      imm32_s;
  logic [XLEN-1:0]  imm_s;
  logic             accept_s;
  logic             pop_s;

  logic             main_valid_q, main_valid_d;
  logic [XLEN-1:0]  main_imm_q, main_imm_d;
  logic [2:0]       main_fmt_q, main_fmt_d;
  logic             main_ill_q, main_ill_d;
  logic [TAG_W-1:0] main_tag_q, main_tag_d;
  logic             skid_valid_q, skid_valid_d;
  logic [XLEN-1:0]  skid_imm_q, skid_imm_d;
  logic [2:0]       skid_fmt_q, skid_fmt_d;
  logic             skid_ill_q, skid_ill_d;
  logic [TAG_W-1:0] skid_tag_q, skid_tag_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Format selection and immediate extraction for the word on the input port.
  always_comb begin
    fmt_s   = fmt_sel;
    ill_s   = 1'b0;
    imm32_s = 32'd0;
    if (AUTO_DECODE != 0) begin
      case (instr[6:0])
        7'b0010011, 7'b0000011, 7'b1100111: fmt_s = FMT_I;
        7'b0100011:                         fmt_s = FMT_S;
        7'b1100011:                         fmt_s = FMT_B;
        7'b0110111, 7'b0010111:             fmt_s = FMT_U;
        7'b1101111:                         fmt_s = FMT_J;
        7'b1110011:                         fmt_s = FMT_Z;
        default:                            fmt_s = FMT_BAD;
      endcase
    end else begin
      fmt_s = fmt_sel;
    end
    case (fmt_s)
      FMT_I: imm32_s = {{21{instr[31]}}, instr[30:20]};
      FMT_S: imm32_s = {{21{instr[31]}}, instr[30:25], instr[11:7]};
      FMT_B: imm32_s = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_U: imm32_s = {instr[31:12], 12'd0};
      FMT_J: imm32_s = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
`ifdef IMMGEN_ZICSR_EN
      FMT_Z: imm32_s = {27'd0, instr[19:15]};
`else
      FMT_Z: ill_s = 1'b1;
`endif
      default: ill_s = 1'b1;
    endcase
    // Every legal 32-bit immediate already carries its sign in bit 31 (Z has it clear).
    imm_s = ill_s ? {XLEN{1'b0}} : XLEN'($signed(imm32_s));
  end

  assign accept_s = in_valid & ~skid_valid_q;
  assign pop_s    = main_valid_q & out_ready;

  // Next state of main/skid registers and the illegal counter.
  always_comb begin
    main_valid_d = main_valid_q;
    main_imm_d   = main_imm_q;
    main_fmt_d   = main_fmt_q;
    main_ill_d   = main_ill_q;
    main_tag_d   = main_tag_q;
    skid_valid_d = skid_valid_q;
    skid_imm_d   = skid_imm_q;
    skid_fmt_d   = skid_fmt_q;
    skid_ill_d   = skid_ill_q;
    skid_tag_d   = skid_tag_q;
    cnt_d        = cnt_q;
    if (flush) begin
      main_valid_d = 1'b0;
      main_imm_d   = {XLEN{1'b0}};
      main_fmt_d   = 3'b000;
      main_ill_d   = 1'b0;
      main_tag_d   = {TAG_W{1'b0}};
      skid_valid_d = 1'b0;
      skid_imm_d   = {XLEN{1'b0}};
      skid_fmt_d   = 3'b000;
      skid_ill_d   = 1'b0;
      skid_tag_d   = {TAG_W{1'b0}};
    end else if (accept_s) begin
      // Skid is empty whenever a word is accepted, so only main can be occupied.
      if (!main_valid_q || out_ready) begin
        main_valid_d = 1'b1;
        main_imm_d   = imm_s;
        main_fmt_d   = fmt_s;
        main_ill_d   = ill_s;
        main_tag_d   = in_tag;
      end else begin
        skid_valid_d = 1'b1;
        skid_imm_d   = imm_s;
        skid_fmt_d   = fmt_s;
        skid_ill_d   = ill_s;
        skid_tag_d   = in_tag;
      end
      if (ill_s && (cnt_q != CNT_MAX)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end else begin
        cnt_d = cnt_q;
      end
    end else if (pop_s) begin
      if (skid_valid_q) begin
        main_imm_d   = skid_imm_q;
        main_fmt_d   = skid_fmt_q;
        main_ill_d   = skid_ill_q;
        main_tag_d   = skid_tag_q;
        skid_valid_d = 1'b0;
      end else begin
        main_valid_d = 1'b0;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      main_imm_q   <= {XLEN{1'b0}};
      main_fmt_q   <= 3'b000;
      main_ill_q   <= 1'b0;
      main_tag_q   <= {TAG_W{1'b0}};
      skid_valid_q <= 1'b0;
      skid_imm_q   <= {XLEN{1'b0}};
      skid_fmt_q   <= 3'b000;
      skid_ill_q   <= 1'b0;
      skid_tag_q   <= {TAG_W{1'b0}};
      cnt_q        <= {CNT_W{1'b0}};
    end else begin
      main_valid_q <= main_valid_d;
      main_imm_q   <= main_imm_d;
      main_fmt_q   <= main_fmt_d;
      main_ill_q   <= main_ill_d;
      main_tag_q   <= main_tag_d;
      skid_valid_q <= skid_valid_d;
      skid_imm_q   <= skid_imm_d;
      skid_fmt_q   <= skid_fmt_d;
      skid_ill_q   <= skid_ill_d;
      skid_tag_q   <= skid_tag_d;
      cnt_q        <= cnt_d;
    end
  end

  assign in_ready    = ~skid_valid_q;
  assign out_valid   = main_valid_q;
  assign out_imm     = main_imm_q;
  assign out_fmt     = main_fmt_q;
  assign out_illegal = main_ill_q;
  assign out_tag     = main_tag_q;
  assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: a default instance (auto-decode, XLEN 32) and a fmt_sel-driven
// XLEN 64 / CNT_W 2 instance share stimulus; a queue scoreboard checks both.
module tb_imm_gen_pipe;

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  fsel;
    logic [3:0]  tag;
    logic [31:0] imm;
    logic [2:0]  fmt1;
    logic        ill1;
    logic [2:0]  fmt2;
    logic        ill2;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] instr = 32'd0;
  logic [2:0]  fmt_sel = 3'd0;
  logic [3:0]  in_tag = 4'd0;
  logic        out_ready = 1'b1;

  logic        in_ready1, out_valid1, out_illegal1;
  logic [31:0] out_imm1;
  logic [2:0]  out_fmt1;
  logic [3:0]  out_tag1;
  logic [15:0] illegal_cnt1;
  logic        in_ready2, out_valid2, out_illegal2;
  logic [63:0] out_imm2;
  logic [2:0]  out_fmt2;
  logic [3:0]  out_tag2;
  logic [1:0]  illegal_cnt2;

  int   n_vec = 0;
  int   n_err = 0;
  bit   mon_en = 1'b0;
  bit   bp_en = 1'b0;
  vec_t cur;
  vec_t q[$];
  int   cnt1_m = 0;
  int   cnt2_m = 0;
  vec_t vt[13];

  imm_gen_pipe #(.XLEN(32), .AUTO_DECODE(1), .TAG_W(4), .CNT_W(16)) dut1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready1),
    .instr(instr), .fmt_sel(fmt_sel), .in_tag(in_tag), .out_valid(out_valid1),
    .out_ready(out_ready), .out_imm(out_imm1), .out_fmt(out_fmt1),
    .out_illegal(out_illegal1), .out_tag(out_tag1), .illegal_cnt(illegal_cnt1));

  imm_gen_pipe #(.XLEN(64), .AUTO_DECODE(0), .TAG_W(4), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready2),
    .instr(instr), .fmt_sel(fmt_sel), .in_tag(in_tag), .out_valid(out_valid2),
    .out_ready(out_ready), .out_imm(out_imm2), .out_fmt(out_fmt2),
    .out_illegal(out_illegal2), .out_tag(out_tag2), .illegal_cnt(illegal_cnt2));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Scoreboard: outputs and counters checked on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("cnt1", 64'(illegal_cnt1), 64'(cnt1_m));
      chk("cnt2", 64'(illegal_cnt2), 64'(cnt2_m));
      chk("out_valid1", 64'(out_valid1), 64'(q.size() != 0));
      chk("out_valid2", 64'(out_valid2), 64'(q.size() != 0));
      chk("in_ready1", 64'(in_ready1), 64'(q.size() < 2));
      chk("in_ready2", 64'(in_ready2), 64'(q.size() < 2));
      if (rst) begin
        q.delete();
        cnt1_m = 0;
        cnt2_m = 0;
      end else if (flush) begin
        q.delete();
      end else begin
        if (out_valid1 && out_ready && q.size() != 0) begin
          vec_t e;
          e = q.pop_front();
          chk("imm1", {32'd0, out_imm1}, e.ill1 ? 64'd0 : {32'd0, e.imm});
          chk("fmt1", 64'(out_fmt1), 64'(e.fmt1));
          chk("ill1", 64'(out_illegal1), 64'(e.ill1));
          chk("tag1", 64'(out_tag1), 64'(e.tag));
          chk("imm2", out_imm2, e.ill2 ? 64'd0 : {{32{e.imm[31]}}, e.imm});
          chk("fmt2", 64'(out_fmt2), 64'(e.fmt2));
          chk("ill2", 64'(out_illegal2), 64'(e.ill2));
          chk("tag2", 64'(out_tag2), 64'(e.tag));
        end
        if (in_valid && in_ready1) begin
          q.push_back(cur);
          if (cur.ill1 && cnt1_m < 65535) cnt1_m++;
          if (cur.ill2 && cnt2_m < 3) cnt2_m++;
        end
      end
    end
  end

  task automatic drive(input vec_t v);
    cur      = v;
    instr    = v.instr;
    fmt_sel  = v.fsel;
    in_tag   = v.tag;
    in_valid = 1'b1;
  endtask

  task automatic send(input vec_t v);
    bit acc;
    acc = 1'b0;
    drive(v);
    for (int k = 0; k < 50 && !acc; k++) begin
      if (bp_en) out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      acc = in_ready1;
      @(posedge clk);
      #1;
    end
    if (!acc) chk("send_timeout", 64'(acc), 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int k = 0; k < 20 && q.size() != 0; k++) begin
      @(posedge clk);
      #1;
    end
    chk("drain_empty", 64'(q.size()), 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    vec_t v;
    logic [15:0] c1_before;
    vt[0]  = '{32'hFFF00093, 3'b000, 4'd1,  32'hFFFFFFFF, 3'b000, 1'b0, 3'b000, 1'b0};
    vt[1]  = '{32'hFE000EE3, 3'b010, 4'd2,  32'hFFFFFFFC, 3'b010, 1'b0, 3'b010, 1'b0};
    vt[2]  = '{32'h123450B7, 3'b011, 4'd3,  32'h12345000, 3'b011, 1'b0, 3'b011, 1'b0};
    vt[3]  = '{32'h008000EF, 3'b100, 4'd4,  32'h00000008, 3'b100, 1'b0, 3'b100, 1'b0};
    vt[4]  = '{32'hFE512C23, 3'b001, 4'd5,  32'hFFFFFFF8, 3'b001, 1'b0, 3'b001, 1'b0};
    vt[5]  = '{32'h7FF12083, 3'b000, 4'd6,  32'h000007FF, 3'b000, 1'b0, 3'b000, 1'b0};
    vt[6]  = '{32'h00008067, 3'b000, 4'd7,  32'h00000000, 3'b000, 1'b0, 3'b000, 1'b0};
    vt[7]  = '{32'hFFFFF097, 3'b011, 4'd8,  32'hFFFFF000, 3'b011, 1'b0, 3'b011, 1'b0};
    vt[8]  = '{32'h7E000FE3, 3'b010, 4'd9,  32'h00000FFE, 3'b010, 1'b0, 3'b010, 1'b0};
    vt[9]  = '{32'hFFFFF06F, 3'b100, 4'd10, 32'hFFFFFFFE, 3'b100, 1'b0, 3'b100, 1'b0};
    vt[10] = '{32'h0000007F, 3'b110, 4'd11, 32'h00000000, 3'b111, 1'b1, 3'b110, 1'b1};
`ifdef IMMGEN_ZICSR_EN
    vt[11] = '{32'h340FD073, 3'b101, 4'd12, 32'h0000001F, 3'b101, 1'b0, 3'b101, 1'b0};
`else
    vt[11] = '{32'h340FD073, 3'b101, 4'd12, 32'h00000000, 3'b101, 1'b1, 3'b101, 1'b1};
`endif
    vt[12] = '{32'hFFF00093, 3'b111, 4'd13, 32'hFFFFFFFF, 3'b000, 1'b0, 3'b111, 1'b1};

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    // Reset state of both instances.
    chk("rst_valid", 64'(out_valid1 | out_valid2), 64'd0);
    chk("rst_ready", 64'(in_ready1 & in_ready2), 64'd1);
    chk("rst_imm", {32'd0, out_imm1} | out_imm2, 64'd0);
    chk("rst_fmt_ill_tag", 64'({out_fmt1, out_illegal1, out_tag1, out_fmt2, out_illegal2, out_tag2}), 64'd0);
    chk("rst_cnt", 64'(illegal_cnt1) | 64'(illegal_cnt2), 64'd0);
    mon_en = 1'b1;

    // Table pass 1: free-flowing output; pass 2: random back-pressure.
    for (int p = 0; p < 2; p++) begin
      bp_en = (p == 1);
      for (int i = 0; i < 13; i++) send(vt[i]);
      bp_en = 1'b0;
      drain();
    end

    // Back-pressure: tags 1,2,3 back to back with the consumer stalled.
    do_reset();
    out_ready = 1'b0;
    send(vt[0]);
    send(vt[1]);
    chk("t3_in_ready_low", 64'(in_ready1), 64'd0);
    chk("t3_main_tag", 64'(out_tag1), 64'd1);
    drive(vt[2]);
    repeat (3) @(posedge clk);
    #1;
    chk("t3_held_tag", 64'(out_tag1), 64'd1);
    chk("t3_still_full", 64'(in_ready1), 64'd0);
    out_ready = 1'b1;
    send(vt[2]);
    drain();

    // Illegal counter saturation on the CNT_W=2 instance.
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      send(vt[10]);
      chk("t4_cnt2", 64'(illegal_cnt2), 64'((k < 3) ? k : 3));
      chk("t4_cnt1", 64'(illegal_cnt1), 64'(k));
    end
    drain();

    // Flush with the skid full and an illegal word presented.
    do_reset();
    out_ready = 1'b0;
    send(vt[0]);
    send(vt[3]);
    v = vt[10];
    drive(v);
    flush = 1'b1;
    c1_before = illegal_cnt1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    chk("t6_out_valid", 64'(out_valid1 | out_valid2), 64'd0);
    chk("t6_in_ready", 64'(in_ready1 & in_ready2), 64'd1);
    chk("t6_cnt", 64'(illegal_cnt1), 64'(c1_before));
    // Flush while ready: the presented illegal word must not be counted.
    drive(v);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    chk("t6b_out_valid", 64'(out_valid1), 64'd0);
    chk("t6b_cnt", 64'(illegal_cnt1) | 64'(illegal_cnt2), 64'd0);
    out_ready = 1'b1;
    send(vt[4]);
    drain();

    // Reset in the middle of a stalled transfer.
    out_ready = 1'b0;
    send(vt[10]);
    send(vt[5]);
    do_reset();
    #1;
    chk("rst_mid_valid", 64'(out_valid1), 64'd0);
    chk("rst_mid_cnt", 64'(illegal_cnt1), 64'd0);
    out_ready = 1'b1;
    send(vt[9]);
    drain();

    @(negedge clk);
    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
